// File: rtl/led_pulse_pio_if.sv
// Avalon-MM slave bus bundle for led_pulse_pio.
// Handshake: a write is accepted on any rising edge where chipselect=1 and
// write_n=0 (no wait states, never back-pressured); reads need no strobe and
// readdata reflects the address presented before the previous edge.
interface led_pulse_pio_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/led_pulse_pio.sv
// Avalon-MM output PIO with set/clear aliases, a one-shot bit-inversion pulse
// engine and a sticky, maskable completion interrupt.
module led_pulse_pio #(
  parameter int          WIDTH       = 10,
  parameter int          LEN_W       = 16,
  parameter logic [31:0] RESET_VALUE = 32'd0
) (
  input  logic              clk,
  input  logic              reset,
  led_pulse_pio_if.slave    bus,
  output logic [WIDTH-1:0]  out_port,
  output logic              irq,
  output logic              o_dbg_state
);

  localparam logic [WIDTH-1:0] L_RST_DATA = RESET_VALUE[WIDTH-1:0];

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_data;
  logic [WIDTH-1:0]   r_pmask;
  logic [LEN_W-1:0]   r_cnt;
  logic [LEN_W-1:0]   r_plen;
  logic               r_done;
  logic               r_ie;
  logic [31:0]        r_readdata;

  logic               w_wr;
  logic [WIDTH-1:0]   w_wmask;
  logic               w_pulse_go;
  logic               w_pulse_zero;
  logic               w_abort;
  logic               w_clr_done;
  logic               w_complete;
  logic               w_busy;
  logic [31:0]        w_rd_mux;

  // Decode the bus write into the individual register actions.
  always_comb begin
    w_wr         = bus.chipselect && !bus.write_n;
    w_wmask      = bus.writedata[WIDTH-1:0];
    w_pulse_go   = w_wr && (bus.address == 3'd2) && (w_wmask != '0) && (r_plen != '0);
    w_pulse_zero = w_wr && (bus.address == 3'd2) && (w_wmask != '0) && (r_plen == '0);
    w_abort      = w_wr && (bus.address == 3'd3) && bus.writedata[0];
    w_clr_done   = w_wr && (bus.address == 3'd3) && bus.writedata[1];
  end

  // Pulse engine state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Pulse engine next state; a retrigger beats completion, completion beats abort.
  always_comb begin
    w_state_next = r_state;
    w_complete   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pulse_go) w_state_next = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (w_pulse_go) begin
          w_state_next = S_ACTIVE;
        end else if (r_cnt == LEN_W'(1)) begin
          w_state_next = S_IDLE;
          w_complete   = 1'b1;
        end else if (w_abort) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_busy      = (r_state == S_ACTIVE);
  assign o_dbg_state = w_busy;

  // Pulse mask and cycle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pmask <= '0;
      r_cnt   <= '0;
    end else if (w_pulse_go) begin
      r_pmask <= w_wmask;
      r_cnt   <= r_plen;
    end else if (w_complete || w_abort) begin
      r_pmask <= '0;
      r_cnt   <= '0;
    end else if (w_busy) begin
      r_cnt   <= r_cnt - LEN_W'(1);
    end
  end

  // Sticky done flag; completion wins over a software clear on the same edge.
  always_ff @(posedge clk) begin
    if (reset)                          r_done <= 1'b0;
    else if (w_complete || w_pulse_zero) r_done <= 1'b1;
    else if (w_clr_done)                r_done <= 1'b0;
  end

  // Software-visible data, pulse length and interrupt enable registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= L_RST_DATA;
      r_plen <= '0;
      r_ie   <= 1'b0;
    end else if (w_wr) begin
      case (bus.address)
        3'd0: r_data <= w_wmask;
        3'd1: r_plen <= bus.writedata[LEN_W-1:0];
        3'd4: r_data <= r_data | w_wmask;
        3'd5: r_data <= r_data & ~w_wmask;
        3'd6: r_ie   <= bus.writedata[0];
        default: ;
      endcase
    end
  end

  // Read mux, zero-extended; write-only and unmapped addresses read 0.
  always_comb begin
    w_rd_mux = 32'd0;
    case (bus.address)
      3'd0: w_rd_mux = 32'(r_data);
      3'd1: w_rd_mux = 32'(r_plen);
      3'd2: w_rd_mux = 32'(r_pmask);
      3'd3: w_rd_mux = {30'd0, r_done, w_busy};
      3'd6: w_rd_mux = {31'd0, r_ie};
      default: w_rd_mux = 32'd0;
    endcase
  end

  // Registered read data, one cycle after address presentation.
  always_ff @(posedge clk) begin
    if (reset) r_readdata <= 32'd0;
    else       r_readdata <= w_rd_mux;
  end

  assign bus.readdata = r_readdata;
  assign out_port     = r_data ^ r_pmask;
  assign irq          = r_done & r_ie;

endmodule
